// File: rtl/rx_credit_allocator.sv
// rx_credit_allocator
// Receive-side flow-control credit allocator. Keeps the advertised credit
// limits for Posted, Non-Posted and Completion traffic (header + data),
// counts credits consumed by received TLPs, flags receiver overflow and
// schedules UpdateFC requests toward the DLL with a valid/ack handshake.
//
// Ports
//   i_Clk, i_ARst (async, active-high), i_SClr (sync clear, same as reset)
//   i_RxTlpVal / i2_RxTlpType / i9_RxTlpDataCred   : received TLP to account
//   i_AppRelVal / i2_AppRelType / i9_AppRelDataCred : buffer space released
//   o8_LimPH/NH/CH, o12_LimPD/ND/CD                 : current limits
//   o_UpdVal / o2_UpdType / o8_UpdHdr / o12_UpdData : UpdateFC request
//   i_UpdAck                                        : DLL accepted request
//   o_Overflow / o2_OvfType                         : sticky overflow + first type
// Type encoding: 0=P, 1=NP, 2=Cpl, 3=ignored.
module rx_credit_allocator #(
    parameter logic [7:0]  P_PH_INIT   = 8'd32,
    parameter logic [11:0] P_PD_INIT   = 12'd256,
    parameter logic [7:0]  P_NH_INIT   = 8'd16,
    parameter logic [11:0] P_ND_INIT   = 12'd16,
    parameter logic [7:0]  P_CH_INIT   = 8'd64,
    parameter logic [11:0] P_CD_INIT   = 12'd512,
    parameter int          P_UPD_TIMER = 1024
) (
    input  logic        i_Clk,
    input  logic        i_ARst,
    input  logic        i_SClr,
    input  logic        i_RxTlpVal,
    input  logic [1:0]  i2_RxTlpType,
    input  logic [8:0]  i9_RxTlpDataCred,
    input  logic        i_AppRelVal,
    input  logic [1:0]  i2_AppRelType,
    input  logic [8:0]  i9_AppRelDataCred,
    output logic [7:0]  o8_LimPH,
    output logic [7:0]  o8_LimNH,
    output logic [7:0]  o8_LimCH,
    output logic [11:0] o12_LimPD,
    output logic [11:0] o12_LimND,
    output logic [11:0] o12_LimCD,
    output logic        o_UpdVal,
    output logic [1:0]  o2_UpdType,
    output logic [7:0]  o8_UpdHdr,
    output logic [11:0] o12_UpdData,
    input  logic        i_UpdAck,
    output logic        o_Overflow,
    output logic [1:0]  o2_OvfType
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
    localparam int TimerW = (P_UPD_TIMER > 1) ? $clog2(P_UPD_TIMER) : 1;

    localparam logic [7:0]  HdrInit  [3] = '{P_PH_INIT, P_NH_INIT, P_CH_INIT};
    localparam logic [11:0] DataInit [3] = '{P_PD_INIT, P_ND_INIT, P_CD_INIT};

    logic [7:0]        limHdr  [3];
    logic [11:0]       limData [3];
    logic [7:0]        rcvHdr  [3];
    logic [11:0]       rcvData [3];
    logic [2:0]        relHit;
    logic [2:0]        ovfHit;
    logic [2:0]        pendingReg;
    logic [2:0]        pendingNext;
    logic [0:0]        stateReg;
    logic [1:0]        rrPtrReg;
    logic [1:0]        selType;
    logic [TimerW-1:0] timerReg;
    logic              timerWrap;

    // Earliest pending type in round-robin order, starting at ptr.
    function automatic logic [1:0] rrPick(input logic [2:0] pend, input logic [1:0] ptr);
        logic [1:0] cand;
        rrPick = ptr;
        for (int k = 2; k >= 0; k--) begin
            cand = 2'((int'(ptr) + k) % 3);
            if (pend[cand]) rrPick = cand;
        end
    endfunction

    // Per-type limit and received-credit accounting.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_type
            logic       rcvHit;
            logic [7:0] rcvHdrNew;
            logic [7:0] hdrRoom;
            logic [11:0] rcvDataNew;
            logic [11:0] dataRoom;

            assign relHit[gi] = i_AppRelVal && (i2_AppRelType == 2'(gi));
            assign rcvHit     = i_RxTlpVal && (i2_RxTlpType == 2'(gi));

            // Room is checked against the limit before any same-cycle release.
            assign rcvHdrNew  = rcvHdr[gi] + 8'd1;
            assign rcvDataNew = rcvData[gi] + {3'b000, i9_RxTlpDataCred};
            assign hdrRoom    = limHdr[gi] - rcvHdrNew;
            assign dataRoom   = limData[gi] - rcvDataNew;
            assign ovfHit[gi] = rcvHit && (hdrRoom[7] || dataRoom[11]);

            always_ff @(posedge i_Clk or posedge i_ARst) begin
                if (i_ARst) begin
                    limHdr[gi]  <= HdrInit[gi];
                    limData[gi] <= DataInit[gi];
                    rcvHdr[gi]  <= 8'd0;
                    rcvData[gi] <= 12'd0;
                end else if (i_SClr) begin
                    limHdr[gi]  <= HdrInit[gi];
                    limData[gi] <= DataInit[gi];
                    rcvHdr[gi]  <= 8'd0;
                    rcvData[gi] <= 12'd0;
                end else begin
                    if (relHit[gi]) begin
                        limHdr[gi]  <= limHdr[gi] + 8'd1;
                        limData[gi] <= limData[gi] + {3'b000, i9_AppRelDataCred};
                    end
                    if (rcvHit) begin
                        rcvHdr[gi]  <= rcvHdrNew;
                        rcvData[gi] <= rcvDataNew;
                    end
                end
            end
        end
    endgenerate

    assign o8_LimPH  = limHdr[0];
    assign o8_LimNH  = limHdr[1];
    assign o8_LimCH  = limHdr[2];
    assign o12_LimPD = limData[0];
    assign o12_LimND = limData[1];
    assign o12_LimCD = limData[2];

    // Refresh timer: free-running, keeps counting while a request is out.
    assign timerWrap = (timerReg == TimerW'(P_UPD_TIMER - 1));

    always_ff @(posedge i_Clk or posedge i_ARst) begin
        if (i_ARst) begin
            timerReg <= '0;
        end else if (i_SClr || timerWrap) begin
            timerReg <= '0;
        end else begin
            timerReg <= timerReg + 1'b1;
        end
    end

    assign selType = rrPick(pendingReg, rrPtrReg);

    // Sets (release, timer) win over the clear of the type being served, so a
    // release landing in the selection cycle still gets its own update.
    always_comb begin
        pendingNext = pendingReg;
        if (stateReg == ST_IDLE && pendingReg != 3'b000) begin
            pendingNext[selType] = 1'b0;
        end
        if (timerWrap) begin
            pendingNext = 3'b111;
        end
        pendingNext = pendingNext | relHit;
    end

    always_ff @(posedge i_Clk or posedge i_ARst) begin
        if (i_ARst) begin
            pendingReg  <= 3'b111;
            stateReg    <= ST_IDLE;
            rrPtrReg    <= 2'd0;
            o_UpdVal    <= 1'b0;
            o2_UpdType  <= 2'd0;
            o8_UpdHdr   <= 8'd0;
            o12_UpdData <= 12'd0;
        end else if (i_SClr) begin
            pendingReg  <= 3'b111;
            stateReg    <= ST_IDLE;
            rrPtrReg    <= 2'd0;
            o_UpdVal    <= 1'b0;
            o2_UpdType  <= 2'd0;
            o8_UpdHdr   <= 8'd0;
            o12_UpdData <= 12'd0;
        end else begin
            pendingReg <= pendingNext;
            case (stateReg)
                ST_IDLE: begin
                    if (pendingReg != 3'b000) begin
                        o_UpdVal   <= 1'b1;
                        o2_UpdType <= selType;
                        stateReg   <= ST_SEND;
                        rrPtrReg   <= (selType == 2'd2) ? 2'd0 : selType + 2'd1;
                        case (selType)
                            2'd1: begin
                                o8_UpdHdr   <= limHdr[1];
                                o12_UpdData <= limData[1];
                            end
                            2'd2: begin
                                o8_UpdHdr   <= limHdr[2];
                                o12_UpdData <= limData[2];
                            end
                            default: begin
                                o8_UpdHdr   <= limHdr[0];
                                o12_UpdData <= limData[0];
                            end
                        endcase
                    end
                end
                default: begin
                    if (i_UpdAck) begin
                        o_UpdVal <= 1'b0;
                        stateReg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Sticky overflow; only the first offending type is recorded.
    always_ff @(posedge i_Clk or posedge i_ARst) begin
        if (i_ARst) begin
            o_Overflow <= 1'b0;
            o2_OvfType <= 2'd0;
        end else if (i_SClr) begin
            o_Overflow <= 1'b0;
            o2_OvfType <= 2'd0;
        end else if (!o_Overflow && ovfHit != 3'b000) begin
            o_Overflow <= 1'b1;
            o2_OvfType <= ovfHit[1] ? 2'd1 : (ovfHit[2] ? 2'd2 : 2'd0);
        end
    end

endmodule

// File: tb/tb_rx_credit_allocator.sv
module tb_rx_credit_allocator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sclr, ack;
    logic        rxVal, relVal;
    logic [1:0]  rxType, relType;
    logic [8:0]  rxData, relData;

    logic [7:0]  limPH, limNH, limCH, updHdr;
    logic [11:0] limPD, limND, limCD, updData;
    logic        updVal, ovf;
    logic [1:0]  updType, ovfType;

    // Second instance: short refresh timer, no traffic, always acked.
    logic        zero1 = 1'b0;
    logic [1:0]  zero2 = 2'd0;
    logic [8:0]  zero9 = 9'd0;
    logic        one1  = 1'b1;
    logic [7:0]  bLimPH, bLimNH, bLimCH, bUpdHdr;
    logic [11:0] bLimPD, bLimND, bLimCD, bUpdData;
    logic        bUpdVal, bOvf;
    logic [1:0]  bUpdType, bOvfType;

    rx_credit_allocator u_dut (
        .i_Clk(clk), .i_ARst(rst), .i_SClr(sclr),
        .i_RxTlpVal(rxVal), .i2_RxTlpType(rxType), .i9_RxTlpDataCred(rxData),
        .i_AppRelVal(relVal), .i2_AppRelType(relType), .i9_AppRelDataCred(relData),
        .o8_LimPH(limPH), .o8_LimNH(limNH), .o8_LimCH(limCH),
        .o12_LimPD(limPD), .o12_LimND(limND), .o12_LimCD(limCD),
        .o_UpdVal(updVal), .o2_UpdType(updType), .o8_UpdHdr(updHdr), .o12_UpdData(updData),
        .i_UpdAck(ack), .o_Overflow(ovf), .o2_OvfType(ovfType)
    );

    rx_credit_allocator #(.P_UPD_TIMER(16)) u_tmr (
        .i_Clk(clk), .i_ARst(rst), .i_SClr(sclr),
        .i_RxTlpVal(zero1), .i2_RxTlpType(zero2), .i9_RxTlpDataCred(zero9),
        .i_AppRelVal(zero1), .i2_AppRelType(zero2), .i9_AppRelDataCred(zero9),
        .o8_LimPH(bLimPH), .o8_LimNH(bLimNH), .o8_LimCH(bLimCH),
        .o12_LimPD(bLimPD), .o12_LimND(bLimND), .o12_LimCD(bLimCD),
        .o_UpdVal(bUpdVal), .o2_UpdType(bUpdType), .o8_UpdHdr(bUpdHdr), .o12_UpdData(bUpdData),
        .i_UpdAck(one1), .o_Overflow(bOvf), .o2_OvfType(bOvfType)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0]  t;
        logic [7:0]  h;
        logic [11:0] d;
    } req_t;
    req_t q[$];

    int hInit[3] = '{32, 16, 64};
    int dInit[3] = '{256, 16, 512};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pushReq(input int t, input int h, input int d);
        req_t r;
        r.t = 2'(t);
        r.h = 8'(h);
        r.d = 12'(d);
        q.push_back(r);
    endtask

    task automatic pushInit;
        for (int t = 0; t < 3; t++) pushReq(t, hInit[t], dInit[t]);
    endtask

    task automatic doSClr;
        q.delete();
        pushInit();
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        repeat (7) step();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the main instance: every cycle a request is presented it
    // must match the head of the queue; it is retired on the handshake.
    always @(negedge clk) begin
        if (!rst && !sclr && updVal) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL upd_unexpected actual type=%0d hdr=%0d data=%0d required=none",
                         updType, updHdr, updData);
            end else begin
                check("upd_type", int'(updType), int'(q[0].t));
                check("upd_hdr", int'(updHdr), int'(q[0].h));
                check("upd_data", int'(updData), int'(q[0].d));
                if (ack) void'(q.pop_front());
            end
        end
    end

    // Monitor for the short-timer instance: P, NP, Cpl repeating, init payloads,
    // and P requests exactly 16 cycles apart.
    int expT = 0;
    int lastP = -1;
    int pSpacings = 0;
    always @(negedge clk) begin
        if (rst || sclr) begin
            expT  = 0;
            lastP = -1;
        end else if (bUpdVal) begin
            check("tmr_type", int'(bUpdType), expT);
            check("tmr_hdr", int'(bUpdHdr), hInit[expT]);
            check("tmr_data", int'(bUpdData), dInit[expT]);
            if (expT == 0) begin
                if (lastP >= 0) begin
                    check("tmr_period", cyc - lastP, 16);
                    pSpacings++;
                end
                lastP = cyc;
            end
            expT = (expT + 1) % 3;
        end
    end

    initial begin
        rst = 1'b1; sclr = 1'b0; ack = 1'b1;
        rxVal = 1'b0; rxType = 2'd0; rxData = 9'd0;
        relVal = 1'b0; relType = 2'd0; relData = 9'd0;
        repeat (3) step();

        // Reset state
        check("rst_updval", int'(updVal), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_ovftype", int'(ovfType), 0);
        check("rst_limph", int'(limPH), 32);
        check("rst_limpd", int'(limPD), 256);
        check("rst_limnh", int'(limNH), 16);
        check("rst_limnd", int'(limND), 16);
        check("rst_limch", int'(limCH), 64);
        check("rst_limcd", int'(limCD), 512);
        check("rst_updhdr", int'(updHdr), 0);
        check("rst_upddata", int'(updData), 0);
        check("rst_updtype", int'(updType), 0);

        // Initial three requests, one cycle each, 2-cycle spacing
        pushInit();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("init_valid_pattern", int'(updVal), (i % 2 == 0) ? 1 : 0);
        end
        step();

        // P release with 8 data credits: limits at n+1, request at n+2
        relVal = 1'b1; relType = 2'd0; relData = 9'd8;
        pushReq(0, 33, 264);
        step();
        relVal = 1'b0;
        check("rel_limph", int'(limPH), 33);
        check("rel_limpd", int'(limPD), 264);
        check("rel_valid_n1", int'(updVal), 0);
        step();
        check("rel_valid_n2", int'(updVal), 1);
        repeat (3) step();
        check("rel_queue_empty", q.size(), 0);

        // Overflow: 32 P receives fit, the 33rd overflows; NP later keeps type
        doSClr();
        rxVal = 1'b1; rxType = 2'd0; rxData = 9'd0;
        repeat (32) step();
        check("ovf_32_none", int'(ovf), 0);
        step();
        check("ovf_33_flag", int'(ovf), 1);
        check("ovf_33_type", int'(ovfType), 0);
        rxType = 2'd1; rxData = 9'd17;
        step();
        rxVal = 1'b0;
        check("ovf_np_flag", int'(ovf), 1);
        check("ovf_np_type_kept", int'(ovfType), 0);

        // 250 P releases (stalled DLL) with matching receives: header wraps to 26
        doSClr();
        ack = 1'b0;
        pushReq(0, 33, 256);
        pushReq(0, 26, 256);
        relVal = 1'b1; relType = 2'd0; relData = 9'd0;
        rxVal = 1'b1; rxType = 2'd0; rxData = 9'd0;
        repeat (250) step();
        relVal = 1'b0; rxVal = 1'b0;
        check("wrap_limph", int'(limPH), 26);
        check("wrap_limpd", int'(limPD), 256);
        check("wrap_no_ovf", int'(ovf), 0);
        ack = 1'b1;
        repeat (6) step();
        check("wrap_queue_empty", q.size(), 0);

        // Stalled NP request with a second NP release during SEND
        doSClr();
        ack = 1'b0;
        relVal = 1'b1; relType = 2'd1; relData = 9'd4;
        pushReq(1, 17, 20);
        step();
        relVal = 1'b0;
        repeat (6) step();
        relVal = 1'b1; relType = 2'd1; relData = 9'd4;
        pushReq(1, 18, 24);
        step();
        relVal = 1'b0;
        repeat (13) step();
        check("stall_limnh", int'(limNH), 18);
        check("stall_limnd", int'(limND), 24);
        check("stall_still_valid", int'(updVal), 1);
        ack = 1'b1;
        repeat (6) step();
        check("stall_queue_empty", q.size(), 0);

        // Synchronous clear in the middle of a stalled request
        doSClr();
        ack = 1'b0;
        rxVal = 1'b1; rxType = 2'd1; rxData = 9'd17;
        relVal = 1'b1; relType = 2'd0; relData = 9'd0;
        pushReq(0, 33, 256);
        step();
        rxVal = 1'b0; relVal = 1'b0;
        check("sclr_pre_ovf", int'(ovf), 1);
        check("sclr_pre_ovftype", int'(ovfType), 1);
        repeat (3) step();
        check("sclr_pre_valid", int'(updVal), 1);
        q.delete();
        pushInit();
        sclr = 1'b1; ack = 1'b1;
        step();
        sclr = 1'b0;
        check("sclr_valid", int'(updVal), 0);
        check("sclr_limph", int'(limPH), 32);
        check("sclr_ovf", int'(ovf), 0);
        check("sclr_ovftype", int'(ovfType), 0);
        repeat (7) step();
        check("sclr_queue_empty", q.size(), 0);

        // Asynchronous reset in the middle of a stalled request
        ack = 1'b0;
        relVal = 1'b1; relType = 2'd2; relData = 9'd0;
        pushReq(2, 65, 512);
        step();
        relVal = 1'b0;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        check("arst_valid_immediate", int'(updVal), 0);
        check("arst_limch", int'(limCH), 64);
        q.delete();
        pushInit();
        ack = 1'b1;
        step();
        rst = 1'b0;
        repeat (7) step();
        check("arst_queue_empty", q.size(), 0);

        repeat (40) step();
        check("tmr_periods_seen", (pSpacings > 0) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
